// File: rtl/interrupt_ctrl.sv
// interrupt_ctrl: prioritised machine interrupt source with timer and register file
module interrupt_ctrl #(
  parameter int NUM_SRC = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               mie,
  input  logic               int_ack,
  input  logic               mret,
  input  logic               reg_we,
  input  logic [1:0]         reg_addr,
  input  logic [31:0]        reg_wdata,
  output logic [31:0]        reg_rdata,
  output logic               interrupt,
  output logic [31:0]        int_cause
);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  state_t state_q, state_d;
  logic [NUM_SRC-1:0] ie_q, ie_d, ip_q, ip_d, prev_q, cand, ack_clr, w1c;
  logic [31:0] mtime_q, mtime_d, cmp_q, cmp_d, cause_q, cause_d;
  logic [15:0] cand16;
  logic [3:0] idx_q, idx_d, widx;
  logic tie_q, tie_d, tmr_q, tmr_d, tpend, tcand, any, still, latch;

  assign tpend = mtime_q >= cmp_q;
  assign tcand = tie_q & tpend;
  assign cand = ie_q & ip_q;
  assign cand16 = 16'(cand);
  assign any = tcand | (|cand);
  assign still = tmr_q ? tcand : cand16[idx_q];
  assign latch = (state_q == IDLE) & any;
  assign interrupt = (state_q == REQ) & mie;
  assign int_cause = cause_q;
  assign reg_rdata = reg_addr == 2'd0 ? {tie_q, 31'(ie_q)} :
                     reg_addr == 2'd1 ? {tpend, 31'(ip_q)} :
                     reg_addr == 2'd2 ? mtime_q : cmp_q;

  always_comb begin
    widx = '0;
    ack_clr = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (cand[i]) widx = 4'(i);
      ack_clr[i] = (state_q == REQ) && int_ack && !tmr_q && idx_q == 4'(i);
    end
    w1c = (reg_we && reg_addr == 2'd1) ? reg_wdata[NUM_SRC-1:0] : '0;
    // a fresh rising edge beats any clear landing in the same cycle
    ip_d = (ip_q & ~w1c & ~ack_clr) | (irq_src & ~prev_q);
    ie_d = (reg_we && reg_addr == 2'd0) ? reg_wdata[NUM_SRC-1:0] : ie_q;
    tie_d = (reg_we && reg_addr == 2'd0) ? reg_wdata[31] : tie_q;
    mtime_d = (reg_we && reg_addr == 2'd2) ? reg_wdata : mtime_q + 32'd1;
    cmp_d = (reg_we && reg_addr == 2'd3) ? reg_wdata : cmp_q;
    state_d = latch ? REQ :
              state_q == REQ ? (int_ack ? SERVICE : still ? REQ : IDLE) :
              (state_q == SERVICE && mret) ? IDLE : state_q;
    tmr_d = latch ? tcand : tmr_q;
    idx_d = latch ? widx : idx_q;
    cause_d = !latch ? cause_q : tcand ? 32'h8000_0007 : 32'h8000_0010 + 32'(widx);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ie_q <= '0;
      tie_q <= 1'b0;
      ip_q <= '0;
      prev_q <= '0;
      mtime_q <= '0;
      cmp_q <= 32'hFFFF_FFFF;
      cause_q <= '0;
      idx_q <= '0;
      tmr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ie_q <= ie_d;
      tie_q <= tie_d;
      ip_q <= ip_d;
      prev_q <= irq_src;
      mtime_q <= mtime_d;
      cmp_q <= cmp_d;
      cause_q <= cause_d;
      idx_q <= idx_d;
      tmr_q <= tmr_d;
    end
  end
endmodule

// File: tb/tb_interrupt_ctrl.sv
// tb_interrupt_ctrl: directed self-checking bench for interrupt_ctrl
module tb_interrupt_ctrl;
  logic clk = 0, rst, mie, int_ack, mret, reg_we, interrupt;
  logic [3:0] irq_src;
  logic [1:0] reg_addr;
  logic [31:0] reg_wdata, reg_rdata, int_cause;
  int n_chk = 0, n_fail = 0;

  interrupt_ctrl #(.NUM_SRC(4)) dut (
    .clk(clk), .rst(rst), .irq_src(irq_src), .mie(mie), .int_ack(int_ack),
    .mret(mret), .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .interrupt(interrupt), .int_cause(int_cause)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
    reg_addr = a;
    #1;
    check(tag, reg_rdata, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    reg_we = 1;
    reg_addr = a;
    reg_wdata = d;
    tick();
    reg_we = 0;
  endtask

  task automatic pulse_ack();
    int_ack = 1;
    tick();
    int_ack = 0;
  endtask

  task automatic pulse_mret();
    mret = 1;
    tick();
    mret = 0;
  endtask

  initial begin
    rst = 1; mie = 1; int_ack = 0; mret = 0; reg_we = 0;
    irq_src = 0; reg_addr = 0; reg_wdata = 0;
    tick();
    check("rst_int", 32'(interrupt), 0);
    check("rst_cause", int_cause, 0);
    chk_reg("rst_ie", 0, 0);
    chk_reg("rst_ip", 1, 0);
    chk_reg("rst_mtime", 2, 0);
    chk_reg("rst_cmp", 3, 32'hFFFF_FFFF);
    rst = 0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk_reg("mtime_cnt", 2, 32'(i));
    end

    wr(0, 32'h1);
    chk_reg("ie_wr", 0, 32'h1);
    irq_src = 4'b0001;
    tick();
    chk_reg("ext_ip", 1, 32'h1);
    check("ext_int_k", 32'(interrupt), 0);
    tick();
    check("ext_int", 32'(interrupt), 1);
    check("ext_cause", int_cause, 32'h8000_0010);
    pulse_ack();
    check("ext_ack_int", 32'(interrupt), 0);
    chk_reg("ext_ack_ip", 1, 0);
    pulse_mret();
    tick();
    check("ext_no_rereq", 32'(interrupt), 0);
    irq_src = 0;

    wr(0, 32'h8000_0006);
    chk_reg("ie_mask", 0, 32'h8000_0006);
    irq_src = 4'b0100;
    tick();
    irq_src = 4'b0110;
    tick();
    check("pri_int", 32'(interrupt), 1);
    check("pri_cause", int_cause, 32'h8000_0012);
    tick();
    check("pri_frozen", int_cause, 32'h8000_0012);
    pulse_ack();
    chk_reg("pri_ip", 1, 32'h2);
    pulse_mret();
    check("pri_mret_int", 32'(interrupt), 0);
    tick();
    check("pri_next_int", 32'(interrupt), 1);
    check("pri_next_cause", int_cause, 32'h8000_0011);
    pulse_ack();
    pulse_mret();
    irq_src = 0;

    wr(0, 0);
    wr(2, 32'hFFFF_FFFD);
    wr(3, 32'h1);
    tick();
    wr(0, 32'h8000_0000);
    chk_reg("tmr_wrap", 2, 0);
    check("tmr_idle", 32'(interrupt), 0);
    tick();
    chk_reg("tmr_ip", 1, 32'h8000_0000);
    check("tmr_int_k", 32'(interrupt), 0);
    tick();
    check("tmr_int", 32'(interrupt), 1);
    check("tmr_cause", int_cause, 32'h8000_0007);
    pulse_ack();
    check("tmr_ack", 32'(interrupt), 0);
    chk_reg("tmr_ip_kept", 1, 32'h8000_0000);
    pulse_mret();
    tick();
    check("tmr_rereq", 32'(interrupt), 1);
    wr(3, 32'hFFFF_FFFF);
    chk_reg("tmr_clr_ip", 1, 0);
    tick();
    check("tmr_clr_int", 32'(interrupt), 0);

    mie = 0;
    wr(0, 32'h1);
    irq_src = 4'b0001;
    tick();
    tick();
    check("mask_mie0", 32'(interrupt), 0);
    mie = 1;
    #1;
    check("mask_mie1", 32'(interrupt), 1);
    wr(1, 32'h1);
    chk_reg("w1c_ip", 1, 0);
    tick();
    check("w1c_idle", 32'(interrupt), 0);
    irq_src = 0;
    tick();
    irq_src = 4'b0001;
    wr(1, 32'h1);
    chk_reg("set_wins", 1, 32'h1);
    tick();
    check("set_req", 32'(interrupt), 1);
    pulse_ack();
    check("svc_int", 32'(interrupt), 0);

    irq_src = 0;
    rst = 1;
    tick();
    rst = 0;
    check("rst2_int", 32'(interrupt), 0);
    check("rst2_cause", int_cause, 0);
    chk_reg("rst2_ip", 1, 0);
    chk_reg("rst2_ie", 0, 0);
    pulse_mret();
    pulse_ack();
    tick();
    check("stray_int", 32'(interrupt), 0);
    check("stray_cause", int_cause, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/interrupt_ctrl.md
# interrupt_ctrl

Machine-level interrupt source for the pipelined core: collects external interrupt request lines and a built-in machine timer, prioritises them, and drives the single `interrupt` request into the exception unit. It holds the request until the exception unit acknowledges that the trap was taken, then stays blocked until `mret`. It also exposes a small register file (enable, pending, mtime, mtimecmp) on a simple synchronous-write / combinational-read bus.

## Interface
- NUM_SRC, 4, number of external interrupt lines (1..16)
- clk  input  1  core clock
- rst  input  1  synchronous, active-high reset
- irq_src  input  NUM_SRC  external requests, synchronous to clk; rising edge sets pending
- mie  input  1  global machine interrupt enable (mstatus.MIE)
- int_ack  input  1  one-cycle pulse: exception unit redirected to mtvec for this interrupt
- mret  input  1  one-cycle pulse: mret retired
- reg_we  input  1  register write strobe
- reg_addr  input  2  register select: 0 IE, 1 IP, 2 MTIME, 3 MTIMECMP
- reg_wdata  input  32  write data
- reg_rdata  output  32  combinational read data for reg_addr
- interrupt  output  1  request to exception unit
- int_cause  output  32  mcause value of the latched request

## Operation
- IE[31:0]: bit i enables external source i (i < NUM_SRC); bit 31 enables timer. Unused bits read 0, writes ignored.
- IP: bit i = external pending (sticky); bit 31 = timer pending (read-only, level). Write-1-to-clear on bits [NUM_SRC-1:0].
- External pending set on rising edge (irq_src & ~prev_src). Set wins over W1C or ack-clear in the same cycle.
- Timer: mtime increments by 1 every cycle, wraps 0xFFFF_FFFF -> 0. Timer pending = (mtime >= mtimecmp), unsigned. A write to MTIME loads reg_wdata that cycle (write beats increment); counting resumes next cycle.
- Candidate = IE & IP. Priority: timer highest, then external source 0, 1, ... ascending index.
- Cause encoding: timer 0x8000_0007; external i 0x8000_0010 + i.
- FSM:
  - IDLE: interrupt=0. If any candidate: latch winner index and cause -> REQ.
  - REQ: interrupt = mie. Latched source/cause frozen (a later higher-priority arrival does not replace it). If the latched source is no longer a candidate (masked, W1C, timer cmp rewritten) -> IDLE, int_cause kept. If int_ack -> SERVICE and clear latched external pending bit (timer not cleared; software rewrites MTIMECMP).
  - SERVICE: interrupt=0; no nesting. mret -> IDLE.
- int_ack outside REQ and mret outside SERVICE are ignored.
- int_ack and loss of the candidate in the same REQ cycle: ack wins -> SERVICE.

## Timing
- Reset (synchronous, rst high at a rising edge): state IDLE, interrupt=0, int_cause=0, IE=0, IP=0, prev_src=0, mtime=0, mtimecmp=0xFFFF_FFFF. reg_rdata follows register contents (0 for addr 0..2 after reset, 0xFFFF_FFFF for addr 3). Reset mid-REQ/SERVICE drops interrupt the next cycle.
- Edge latency: irq_src high before edge k -> IP bit 1 after edge k -> REQ and interrupt high after edge k+1 (2 cycles).
- Timer: mtime reaching mtimecmp after edge k -> IP[31]=1 immediately (combinational) -> interrupt high after edge k+1.
- int_ack sampled at edge k -> interrupt 0 after edge k; pending clear visible after edge k.
- mret at edge k -> IDLE after k; a still-pending candidate re-raises interrupt after edge k+1.
- Register write effects visible in reg_rdata the cycle after the write edge.
- interrupt is gated by mie combinationally within REQ (no extra cycle).

## Test plan
- Reset: rst=1 one edge -> interrupt=0, reg_rdata addr3=0xFFFF_FFFF, addr0..2 =0; mtime counts 1,2,3 afterwards.
- External edge: IE=0x1, mie=1, irq_src[0] 0->1 before edge k -> IP=0x1 after k, interrupt=1, int_cause=0x8000_0010 after k+1; int_ack -> interrupt=0, IP=0; mret -> IDLE, no re-request.
- Priority/freeze: IE=0x8000_0006, src2 edge at k, src1 edge at k+1 -> cause 0x8000_0012 stays latched; after ack+mret, cause 0x8000_0011 two cycles later.
- Timer: write MTIME=0xFFFF_FFFD, MTIMECMP=0x0000_0001, IE=0x8000_0000 -> wrap to 0, interrupt when mtime=1, cause 0x8000_0007; after ack+mret with cmp unchanged, re-requests; write MTIMECMP=0xFFFF_FFFF clears.
- Masking: REQ with mie=0 -> interrupt=0 while REQ held; W1C of latched bit -> IDLE next cycle; edge and W1C same cycle -> bit stays 1.
- Reset mid-SERVICE: rst asserted in SERVICE -> IDLE, IP=0, interrupt=0; stray mret/int_ack afterwards ignored.
